// File: rtl/instr_mem_loader_pkg.sv
// Shared constants, state encoding and frame-header helper for the boot-time program loader.
package instr_mem_loader_pkg;

  localparam int          DEF_ADDR_W    = 5;
  localparam int          DEF_DEPTH     = 32;
  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  // Word count must be non-zero and fit in memory; compared on the full byte so large N never wraps.
  function automatic logic count_ok(input logic [7:0] n, input logic [7:0] depth);
    return (n != 8'd0) && (n <= depth);
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_valid pulses with the 4th byte.
module instr_mem_loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shift_q, shift_d;

  // Only three bytes are stored; the 4th arrives live and completes the word combinationally.
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear) begin
      lane_d  = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {byte_in, shift_q[23:8]};
    end
  end

  assign word_valid = byte_valid && (lane_q == 2'd3);
  assign word       = {byte_in, shift_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: parses SYNC/N/data/CK frames, writes packed words to instruction memory, stalls the core.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int         ADDR_W    = DEF_ADDR_W,
  parameter int         DEPTH     = DEF_DEPTH,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              load_mem_en,
  output logic [ADDR_W-1:0] load_mem_addr,
  output logic [31:0]       load_mem_data,
  output logic              core_stall,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [7:0]    DEPTH_B = 8'(DEPTH);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic                rx_ready_q, rx_ready_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [7:0]          csum_q, csum_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;

  logic                xfer;
  logic                pack_clear;
  logic                word_valid;
  logic [31:0]         word;

  assign xfer = rx_valid && rx_ready_q;

  instr_mem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear),
    .byte_valid (xfer && (state_q == ST_DATA)),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d    = state_q;
    rx_ready_d = rx_ready_q;
    en_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    csum_d     = csum_q;
    count_d    = count_q;
    idx_d      = idx_q;
    pack_clear = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_SYNC;
          rx_ready_d = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          csum_d     = 8'd0;
          idx_d      = '0;
          pack_clear = 1'b1;
        end
      end
      ST_SYNC: begin
        if (xfer && (rx_data == SYNC_BYTE)) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (xfer) begin
          if (count_ok(rx_data, DEPTH_B)) begin
            count_d = rx_data[ADDR_W:0];
            state_d = ST_DATA;
          end else begin
            state_d    = ST_ERR;
            err_d      = 1'b1;
            busy_d     = 1'b0;
            rx_ready_d = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          csum_d = csum_q ^ rx_data;
          if (word_valid) begin
            state_d    = ST_WRITE;
            rx_ready_d = 1'b0;
            en_d       = 1'b1;
            addr_d     = idx_q;
            data_d     = word;
          end
        end
      end
      ST_WRITE: begin
        rx_ready_d = 1'b1;
        if ({1'b0, idx_q} == count_q - ONE) begin
          state_d = ST_CHECK;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_CHECK: begin
        if (xfer) begin
          rx_ready_d = 1'b0;
          busy_d     = 1'b0;
          if (rx_data == csum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rx_ready_q <= 1'b0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      csum_q     <= 8'd0;
      count_q    <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      csum_q     <= csum_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
    end
  end

  assign rx_ready      = rx_ready_q;
  assign load_mem_en   = en_q;
  assign load_mem_addr = addr_q;
  assign load_mem_data = data_q;
  assign busy          = busy_q;
  assign core_stall    = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule
